// File: rtl/alu_pkg.sv
// Shared opcode and state encodings for the ALU accumulator sequencer.
package alu_pkg;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_INC = 3'b010;
   localparam logic [2:0] OP_DEC = 3'b011;
   localparam logic [2:0] OP_AND = 3'b100;
   localparam logic [2:0] OP_OR  = 3'b101;
   localparam logic [2:0] OP_XOR = 3'b110;
   localparam logic [2:0] OP_NOT = 3'b111;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      EXEC = ST_EXEC,
      RESP = ST_RESP
   } state_t;

   // Bitwise ops occupy the upper half of the opcode space and never produce a flag.
   function automatic logic is_logic_op(input logic [2:0] op);
      return op[2];
   endfunction

endpackage

// File: rtl/alu_acc_sequencer_if.sv
// Command and result handshakes between a command source/result consumer and the sequencer.
interface alu_acc_sequencer_if #(parameter int N = 4);

   logic         cmd_valid;
   logic         cmd_ready;
   logic         cmd_load;
   logic [2:0]   cmd_op;
   logic [N-1:0] cmd_operand;
   logic         res_valid;
   logic         res_ready;
   logic [N-1:0] res_data;
   logic         res_carry;

   modport master (
      output cmd_valid, cmd_load, cmd_op, cmd_operand, res_ready,
      input  cmd_ready, res_valid, res_data, res_carry
   );

   modport slave (
      input  cmd_valid, cmd_load, cmd_op, cmd_operand, res_ready,
      output cmd_ready, res_valid, res_data, res_carry
   );

endinterface

// File: rtl/alu_core.sv
// Combinational N-bit ALU; bit N carries the natural carry/borrow of arithmetic ops.
module alu_core
   import alu_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic [2:0]   sel,
   output logic [N:0]   y
);

   always_comb begin
      y = '0;
      case (sel)
         OP_ADD:  y = {1'b0, a} + {1'b0, b};
         OP_SUB:  y = {1'b0, a} - {1'b0, b};
         OP_INC:  y = {1'b0, a} + (N+1)'(1);
         OP_DEC:  y = {1'b0, a} - (N+1)'(1);
         OP_AND:  y = {1'b0, a & b};
         OP_OR:   y = {1'b0, a | b};
         OP_XOR:  y = {1'b0, a ^ b};
         OP_NOT:  y = ~{1'b0, a};
         default: y = '0;
      endcase
   end

endmodule

// File: rtl/alu_acc_sequencer.sv
// Flow-controlled accumulator machine: IDLE accepts a command, EXEC applies it through
// alu_core, RESP holds the result until the consumer takes it.
module alu_acc_sequencer
   import alu_pkg::*;
#(
   parameter int N = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   alu_acc_sequencer_if.slave  bus,
   output logic                busy
);

   state_t       state;
   logic [N-1:0] acc;
   logic         carry;
   logic         cmd_ready_r;
   logic         res_valid_r;
   logic         cap_load;
   logic [2:0]   cap_op;
   logic [N-1:0] cap_operand;
   logic [N:0]   alu_y;

   alu_core #(.N(N)) u_core (
      .a   (acc),
      .b   (cap_operand),
      .sel (cap_op),
      .y   (alu_y)
   );

   assign bus.cmd_ready = cmd_ready_r;
   assign bus.res_valid = res_valid_r;
   assign bus.res_data  = acc;
   assign bus.res_carry = carry;

   // cmd_ready is a register so it stays low throughout reset and rises one edge after release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cmd_ready_r <= 1'b0;
         res_valid_r <= 1'b0;
         busy        <= 1'b0;
         acc         <= '0;
         carry       <= 1'b0;
         cap_load    <= 1'b0;
         cap_op      <= OP_ADD;
         cap_operand <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.cmd_valid && cmd_ready_r) begin
                  cap_load    <= bus.cmd_load;
                  cap_op      <= bus.cmd_op;
                  cap_operand <= bus.cmd_operand;
                  cmd_ready_r <= 1'b0;
                  busy        <= 1'b1;
                  state       <= EXEC;
               end else begin
                  cmd_ready_r <= 1'b1;
               end
            end
            EXEC: begin
               if (cap_load) begin
                  acc   <= cap_operand;
                  carry <= 1'b0;
               end else begin
                  acc   <= alu_y[N-1:0];
                  carry <= is_logic_op(cap_op) ? 1'b0 : alu_y[N];
               end
               res_valid_r <= 1'b1;
               state       <= RESP;
            end
            RESP: begin
               if (bus.res_ready) begin
                  res_valid_r <= 1'b0;
                  busy        <= 1'b0;
                  cmd_ready_r <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: begin
               res_valid_r <= 1'b0;
               busy        <= 1'b0;
               cmd_ready_r <= 1'b0;
               state       <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_acc_sequencer.sv
// Self-checking bench: directed scenarios plus randomized commands against an arithmetic model.
module tb_alu_acc_sequencer;
   import alu_pkg::*;

   localparam int N = 4;
   localparam int M = 1 << N;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic busy;

   alu_acc_sequencer_if #(.N(N)) bus ();

   alu_acc_sequencer #(.N(N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave),
      .busy  (busy)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int acc_m = 0;
   int carry_m = 0;
   int hs_cnt = 0;

   always @(posedge clk)
      if (rst_n && bus.res_valid && bus.res_ready) hs_cnt <= hs_cnt + 1;

   // Reference: accumulator semantics straight from the opcode table, modulo 2^N.
   task automatic model_step(input bit load, input int op, input int b);
      if (load) begin
         acc_m = b; carry_m = 0;
      end else begin
         case (op)
            0: begin carry_m = (acc_m + b >= M) ? 1 : 0; acc_m = (acc_m + b) % M; end
            1: begin carry_m = (acc_m < b) ? 1 : 0; acc_m = (acc_m - b + M) % M; end
            2: begin carry_m = (acc_m == M - 1) ? 1 : 0; acc_m = (acc_m + 1) % M; end
            3: begin carry_m = (acc_m == 0) ? 1 : 0; acc_m = (acc_m + M - 1) % M; end
            4: begin carry_m = 0; acc_m = acc_m & b; end
            5: begin carry_m = 0; acc_m = acc_m | b; end
            6: begin carry_m = 0; acc_m = acc_m ^ b; end
            default: begin carry_m = 0; acc_m = (M - 1) - acc_m; end
         endcase
      end
   endtask

   // Drives one command through both handshakes; ok=0 if either wait times out.
   task automatic send_cmd(input bit load, input int op, input int b, input bit hold_ready,
                           input int rdelay, output int data, output int cy, output bit ok);
      int n;
      ok = 1'b1; data = -1; cy = -1;
      bus.cmd_valid = 1'b1; bus.cmd_load = load; bus.cmd_op = 3'(op); bus.cmd_operand = N'(b);
      n = 0;
      while (bus.cmd_ready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
      if (bus.cmd_ready !== 1'b1) begin ok = 1'b0; bus.cmd_valid = 1'b0; return; end
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      n = 0;
      while (bus.res_valid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
      if (bus.res_valid !== 1'b1) begin ok = 1'b0; return; end
      data = int'(bus.res_data); cy = int'(bus.res_carry);
      repeat (rdelay) begin @(posedge clk); #1; end
      bus.res_ready = 1'b1;
      @(posedge clk); #1;
      if (!hold_ready) bus.res_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if ({bus.cmd_ready, bus.res_valid, busy, bus.res_carry} !== 4'b0000 || bus.res_data !== 4'h0) begin
         bad++;
         $display("FAIL reset_hold: rdy=%b vld=%b busy=%b data=%h carry=%b expected all 0",
                  bus.cmd_ready, bus.res_valid, busy, bus.res_data, bus.res_carry);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      total++;
      if (bus.cmd_ready !== 1'b1 || bus.res_valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_release: rdy=%b vld=%b expected rdy=1 vld=0", bus.cmd_ready, bus.res_valid);
      end
      // park a loaded result in RESP, then pulse reset mid-cycle
      bus.cmd_valid = 1'b1; bus.cmd_load = 1'b1; bus.cmd_op = 3'd0; bus.cmd_operand = 4'h7;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      @(posedge clk); #1;
      total++;
      if (bus.res_valid !== 1'b1 || bus.res_data !== 4'h7) begin
         bad++;
         $display("FAIL reset_preload: vld=%b data=%h expected vld=1 data=7", bus.res_valid, bus.res_data);
      end
      #3 rst_n = 1'b0;
      #1;
      total++;
      if ({bus.cmd_ready, bus.res_valid, busy, bus.res_carry} !== 4'b0000 || bus.res_data !== 4'h0) begin
         bad++;
         $display("FAIL reset_async: rdy=%b vld=%b busy=%b data=%h carry=%b expected all 0",
                  bus.cmd_ready, bus.res_valid, busy, bus.res_data, bus.res_carry);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      total++;
      if (bus.cmd_ready !== 1'b1 || bus.res_valid !== 1'b0 || bus.res_data !== 4'h0) begin
         bad++;
         $display("FAIL reset_after_pulse: rdy=%b vld=%b data=%h expected rdy=1 vld=0 data=0",
                  bus.cmd_ready, bus.res_valid, bus.res_data);
      end
      acc_m = 0; carry_m = 0;
   endtask

   task automatic test_load_add();
      bit ld[2] = '{1'b1, 1'b0};
      int op[2] = '{0, 0};
      int b[2]  = '{9, 8};
      int ed[2] = '{9, 1};
      int ec[2] = '{0, 1};
      int d, c; bit ok;
      for (int i = 0; i < 2; i++) begin
         send_cmd(ld[i], op[i], b[i], 1'b0, 0, d, c, ok);
         model_step(ld[i], op[i], b[i]);
         total++;
         if (!ok || d !== ed[i] || c !== ec[i]) begin
            bad++;
            $display("FAIL load_add[%0d]: ok=%b data=%h carry=%0d expected data=%h carry=%0d", i, ok, d, c, ed[i], ec[i]);
         end
      end
   endtask

   task automatic test_sub_borrow();
      bit ld[3] = '{1'b1, 1'b0, 1'b0};
      int op[3] = '{0, 1, 1};
      int b[3]  = '{3, 5, 14};
      int ed[3] = '{3, 14, 0};
      int ec[3] = '{0, 1, 0};
      int d, c; bit ok;
      for (int i = 0; i < 3; i++) begin
         send_cmd(ld[i], op[i], b[i], 1'b0, 1, d, c, ok);
         model_step(ld[i], op[i], b[i]);
         total++;
         if (!ok || d !== ed[i] || c !== ec[i]) begin
            bad++;
            $display("FAIL sub_borrow[%0d]: ok=%b data=%h carry=%0d expected data=%h carry=%0d", i, ok, d, c, ed[i], ec[i]);
         end
      end
   endtask

   task automatic test_wrap();
      bit ld[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      int op[5] = '{0, 2, 3, 7, 6};
      int b[5]  = '{15, 9, 9, 9, 10};
      int ed[5] = '{15, 0, 15, 0, 10};
      int ec[5] = '{0, 1, 1, 0, 0};
      int d, c; bit ok;
      for (int i = 0; i < 5; i++) begin
         send_cmd(ld[i], op[i], b[i], 1'b0, 0, d, c, ok);
         model_step(ld[i], op[i], b[i]);
         total++;
         if (!ok || d !== ed[i] || c !== ec[i]) begin
            bad++;
            $display("FAIL wrap[%0d]: ok=%b data=%h carry=%0d expected data=%h carry=%0d", i, ok, d, c, ed[i], ec[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      int d, c, n; bit ok;
      send_cmd(1'b1, 0, 6, 1'b0, 0, d, c, ok);
      model_step(1'b1, 0, 6);
      total++;
      if (!ok || d !== acc_m || c !== carry_m) begin
         bad++; $display("FAIL bp_load: ok=%b data=%h expected %h", ok, d, acc_m);
      end
      bus.cmd_valid = 1'b1; bus.cmd_load = 1'b0; bus.cmd_op = 3'd0; bus.cmd_operand = 4'h5;
      @(posedge clk); #1;
      model_step(1'b0, 0, 5);
      // next command offered while the first is still in flight
      bus.cmd_op = 3'd1; bus.cmd_operand = 4'h3;
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
         total++;
         if (bus.res_valid !== 1'b1 || int'(bus.res_data) !== acc_m || int'(bus.res_carry) !== carry_m
             || bus.cmd_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_hold[%0d]: vld=%b data=%h carry=%b rdy=%b expected vld=1 data=%h carry=%0d rdy=0",
                     i, bus.res_valid, bus.res_data, bus.res_carry, bus.cmd_ready, acc_m, carry_m);
         end
         @(posedge clk); #1;
      end
      bus.res_ready = 1'b1;
      @(posedge clk); #1;
      bus.res_ready = 1'b0;
      total++;
      if (bus.cmd_ready !== 1'b1 || bus.res_valid !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL bp_after_hs: rdy=%b vld=%b busy=%b expected rdy=1 vld=0 busy=0", bus.cmd_ready, bus.res_valid, busy);
      end
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      model_step(1'b0, 1, 3);
      total++;
      if (busy !== 1'b1 || bus.cmd_ready !== 1'b0) begin
         bad++; $display("FAIL bp_accept: busy=%b rdy=%b expected busy=1 rdy=0", busy, bus.cmd_ready);
      end
      n = 0;
      while (bus.res_valid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
      total++;
      if (bus.res_valid !== 1'b1 || int'(bus.res_data) !== acc_m || int'(bus.res_carry) !== carry_m) begin
         bad++;
         $display("FAIL bp_second: vld=%b data=%h carry=%b expected vld=1 data=%h carry=%0d",
                  bus.res_valid, bus.res_data, bus.res_carry, acc_m, carry_m);
      end
      bus.res_ready = 1'b1;
      @(posedge clk); #1;
      bus.res_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      int d, c, hs0, ld, op, b; bit ok;
      hs0 = hs_cnt;
      bus.res_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         ld = ($urandom_range(0, 3) == 0) ? 1 : 0;
         op = int'($urandom_range(0, 7));
         b  = int'($urandom_range(0, M - 1));
         send_cmd(ld[0], op, b, 1'b1, 0, d, c, ok);
         model_step(ld[0], op, b);
         total++;
         if (!ok || d !== acc_m || c !== carry_m) begin
            bad++;
            $display("FAIL b2b[%0d]: ok=%b op=%0d ld=%0d b=%h data=%h carry=%0d expected data=%h carry=%0d",
                     i, ok, op, ld, b, d, c, acc_m, carry_m);
         end
      end
      repeat (3) @(posedge clk);
      #1;
      bus.res_ready = 1'b0;
      total++;
      if (hs_cnt - hs0 !== 8) begin
         bad++; $display("FAIL b2b_count: results=%0d expected 8", hs_cnt - hs0);
      end
   endtask

   task automatic test_reset_mid_op();
      int d, c, hs0; bit ok, seen;
      send_cmd(1'b1, 0, 3, 1'b0, 0, d, c, ok);
      model_step(1'b1, 0, 3);
      total++;
      if (!ok || d !== 3) begin
         bad++; $display("FAIL midop_load: ok=%b data=%h expected 3", ok, d);
      end
      hs0 = hs_cnt;
      bus.cmd_valid = 1'b1; bus.cmd_load = 1'b0; bus.cmd_op = 3'd0; bus.cmd_operand = 4'h5;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      total++;
      if (busy !== 1'b1 || bus.res_valid !== 1'b0) begin
         bad++; $display("FAIL midop_exec: busy=%b vld=%b expected busy=1 vld=0", busy, bus.res_valid);
      end
      rst_n = 1'b0;
      #1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      bus.res_ready = 1'b1;
      seen = 1'b0;
      repeat (10) begin
         @(posedge clk); #1;
         if (bus.res_valid === 1'b1) seen = 1'b1;
      end
      bus.res_ready = 1'b0;
      total++;
      if (seen || hs_cnt != hs0 || bus.res_data !== 4'h0 || bus.res_carry !== 1'b0) begin
         bad++;
         $display("FAIL midop_drop: seen=%b results=%0d data=%h carry=%b expected seen=0 results=0 data=0 carry=0",
                  seen, hs_cnt - hs0, bus.res_data, bus.res_carry);
      end
      acc_m = 0; carry_m = 0;
   endtask

   task automatic test_random();
      int d, c, ld, op, b; bit ok;
      for (int i = 0; i < 40; i++) begin
         ld = ($urandom_range(0, 4) == 0) ? 1 : 0;
         op = int'($urandom_range(0, 7));
         b  = int'($urandom_range(0, M - 1));
         send_cmd(ld[0], op, b, 1'b0, int'($urandom_range(0, 3)), d, c, ok);
         model_step(ld[0], op, b);
         total++;
         if (!ok || d !== acc_m || c !== carry_m) begin
            bad++;
            $display("FAIL random[%0d]: ok=%b op=%0d ld=%0d b=%h data=%h carry=%0d expected data=%h carry=%0d",
                     i, ok, op, ld, b, d, c, acc_m, carry_m);
         end
      end
   endtask

   initial begin
      bus.cmd_valid = 1'b0; bus.cmd_load = 1'b0; bus.cmd_op = 3'd0; bus.cmd_operand = '0;
      bus.res_ready = 1'b0;
      test_reset();
      test_load_add();
      test_sub_borrow();
      test_wrap();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_op();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1);
   end

endmodule
